// File: rtl/multi_timer.sv
// Purpose   : N_CH independent down-counting timers behind a word-addressed register bus, with per-channel and combined interrupts.
// Latency   : Dout is combinational. PEND rises (PSC+1)*max(PRESET,1)+2 cycles after the EN write (PSC is 0 when the prescaler is absent).
// Backpressure: none. Every access completes in one cycle and a channel pauses for any cycle in which its CTRL or PRESET is written.
//
// Ports: clk (rising edge), reset (async, active low), Addr[31:2] (Addr[3:2] register, Addr[5:4] channel),
//        WE/Din (register write), Dout (read data), irq_vec (PEND & IM per channel), IRQ (OR of irq_vec).
// Register map per channel: 0 CTRL {PSC[7:4], IM[3], MODE[2:1], EN[0]}, 1 PRESET, 2 COUNT (read-only), 3 STATUS {PEND[0]} (write 1 to clear).
// Build option: define MULTI_TIMER_PRESCALE_EN to add the per-channel 4-bit prescaler. Without it, CTRL[7:4] reads 0.
module multi_timer #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    output logic [N_CH-1:0] irq_vec,
    output logic            IRQ
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    logic [1:0]  reg_sel;
    logic [1:0]  ch_sel;
    logic [31:0] rd_ch [N_CH];
    logic        unused_bits;

    assign reg_sel     = Addr[3:2];
    assign ch_sel      = Addr[5:4];
    assign unused_bits = ^{Addr[31:6], Din};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic             en_q, en_d, im_q, pend_q, set_pend, tick;
        logic [1:0]       mode_q;
        logic [3:0]       psc_q;
        logic [CNT_W-1:0] preset_q, count_q, count_d;
        logic             sel, wr_ctrl, wr_preset, wr_status, hold, one_shot;
        logic [31:0]      rd_w;

        assign sel       = (ch_sel == 2'(i));
        assign wr_ctrl   = WE && sel && (reg_sel == REG_CTRL);
        assign wr_preset = WE && sel && (reg_sel == REG_PRESET);
        assign wr_status = WE && sel && (reg_sel == 2'd3);
        // A configuration write freezes this channel for that cycle, so a new setting never collides with an FSM update.
        assign hold      = wr_ctrl | wr_preset;
        // MODE 10 and 11 behave as auto-reload.
        assign one_shot  = (mode_q == 2'b00);

`ifdef MULTI_TIMER_PRESCALE_EN
        logic [3:0] pcnt_q, pcnt_d;
        assign tick = (pcnt_q == psc_q);
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                psc_q  <= '0;
                pcnt_q <= '0;
            end else begin
                if (wr_ctrl) psc_q <= Din[7:4];
                pcnt_q <= pcnt_d;
            end
        end
`else
        assign psc_q = 4'd0;
        assign tick  = 1'b1;
`endif

        always_comb begin
            state_d  = state_q;
            count_d  = count_q;
            en_d     = en_q;
            set_pend = 1'b0;
`ifdef MULTI_TIMER_PRESCALE_EN
            pcnt_d   = pcnt_q;
`endif
            if (!hold) begin
                case (state_q)
                    S_IDLE: if (en_q) state_d = S_LOAD;
                    S_LOAD: begin
                        count_d = preset_q;
`ifdef MULTI_TIMER_PRESCALE_EN
                        pcnt_d  = '0;
`endif
                        state_d = S_CNT;
                    end
                    S_CNT: begin
                        if (!en_q) begin
                            state_d = S_IDLE;
                        end else begin
                            if (tick) begin
                                // Reaching 1 or starting at 0 both end the period, so PRESET=0 acts like PRESET=1.
                                if (count_q > CNT_W'(1)) begin
                                    count_d = count_q - CNT_W'(1);
                                end else begin
                                    count_d  = '0;
                                    set_pend = 1'b1;
                                    state_d  = S_INT;
                                end
                            end
`ifdef MULTI_TIMER_PRESCALE_EN
                            pcnt_d = tick ? 4'd0 : pcnt_q + 4'd1;
`endif
                        end
                    end
                    S_INT: begin
                        if (one_shot) begin
                            en_d    = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q  <= S_IDLE;
                en_q     <= 1'b0;
                mode_q   <= '0;
                im_q     <= 1'b0;
                preset_q <= '0;
                count_q  <= '0;
                pend_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                // Setting PEND wins over a write-1-to-clear in the same cycle.
                pend_q  <= set_pend | (pend_q & ~(wr_status & Din[0]));
                if (wr_ctrl) begin
                    en_q   <= Din[0];
                    mode_q <= Din[2:1];
                    im_q   <= Din[3];
                end else begin
                    en_q <= en_d;
                end
                if (wr_preset) preset_q <= Din[CNT_W-1:0];
            end
        end

        always_comb begin
            rd_w = '0;
            case (reg_sel)
                REG_CTRL:   rd_w[7:0]       = {psc_q, im_q, mode_q, en_q};
                REG_PRESET: rd_w[CNT_W-1:0] = preset_q;
                REG_COUNT:  rd_w[CNT_W-1:0] = count_q;
                default:    rd_w[0]         = pend_q;
            endcase
        end

        assign rd_ch[i]   = rd_w;
        assign irq_vec[i] = pend_q & im_q;
    end

    // Channel indices at or above N_CH match no entry and read as 0.
    always_comb begin
        Dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == 2'(i)) Dout = rd_ch[i];
        end
    end

    assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Purpose   : Self-checking bench for multi_timer: register reads and interrupt timing are compared against scoreboard queues.
// Latency   : Each expected IRQ rise is queued with the cycle it must occur on. Each expected read value is queued when the read is issued.
// Backpressure: none. Every wait is bounded by a cycle budget.
module tb_multi_timer;
    localparam logic [1:0] R_CTRL = 2'd0;
    localparam logic [1:0] R_PRE  = 2'd1;
    localparam logic [1:0] R_CNT  = 2'd2;
    localparam logic [1:0] R_STAT = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout, Dout_b;
    logic [3:0]  irq_vec;
    logic [1:0]  irq_vec_b;
    logic        IRQ, IRQ_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int w;
    logic irq_prev = 1'b0;
    int          ev_q [$];
    logic [31:0] rd_q [$];

    multi_timer u_dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .irq_vec(irq_vec), .IRQ(IRQ)
    );

    multi_timer #(.N_CH(2), .CNT_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout_b), .irq_vec(irq_vec_b), .IRQ(IRQ_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every IRQ rise must match the next queued cycle.
    always @(negedge clk) begin
        if (reset && IRQ && !irq_prev) begin
            check("irq_expected", 32'(ev_q.size() != 0), 32'd1);
            if (ev_q.size() != 0) check("irq_cycle", cyc, ev_q.pop_front());
        end
        irq_prev = IRQ;
    end

    task automatic wr(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] d);
        Addr = '0;
        Addr[5:2] = {ch, r};
        Din = d;
        WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] e, input string tag);
        Addr = '0;
        Addr[5:2] = {ch, r};
        WE = 1'b0;
        rd_q.push_back(e);
        #1;
        check(tag, Dout, rd_q.pop_front());
        @(negedge clk);
    endtask

    task automatic rdb(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] e, input string tag);
        Addr = '0;
        Addr[5:2] = {ch, r};
        WE = 1'b0;
        rd_q.push_back(e);
        #1;
        check(tag, Dout_b, rd_q.pop_front());
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc < t && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ev(input int budget);
        int n = 0;
        while (ev_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ev_q.size() != 0) begin
            check("ev_timeout", ev_q.size(), 0);
            ev_q.delete();
        end
    endtask

    initial begin
        ticks(2);
        // Reset state
        check("rst_irq", IRQ, 0);
        check("rst_irq_vec", irq_vec, 0);
        check("rst_irq_b", {IRQ_b, irq_vec_b}, 0);
        rd(0, R_CTRL, 0, "rst_ctrl");
        rd(0, R_CNT, 0, "rst_count");
        reset = 1'b1;
        ticks(1);
        check("post_rst_irq", IRQ, 0);

        // Channel 0: one-shot, PRESET=5, IRQ expected 7 cycles after the CTRL write
        wr(0, R_PRE, 5);
        wr(0, R_CTRL, 32'h9);
        ev_q.push_back(cyc + 7);
        wait_ev(50);
        ticks(2);
        rd(0, R_CTRL, 32'h8, "oneshot_en_clr");
        rd(0, R_CNT, 0, "oneshot_count");
        rd(0, R_STAT, 1, "oneshot_pend");
        check("oneshot_irq", IRQ, 1);
        // PEND survives a re-enable. A W1C with Din[0]=0 leaves it set.
        wr(0, R_CTRL, 32'h1);
        rd(0, R_STAT, 1, "pend_across_en");
        check("irq_masked", IRQ, 0);
        ticks(10);
        wr(0, R_STAT, 0);
        rd(0, R_STAT, 1, "w1c_zero_noop");
        wr(0, R_STAT, 1);
        rd(0, R_STAT, 0, "w1c_clear");

        // Channel 2: auto-reload, PRESET=3, IRQ period 5 cycles
        wr(2, R_PRE, 3);
        wr(2, R_CTRL, 32'hB);
        w = cyc;
        ev_q.push_back(w + 5);
        ev_q.push_back(w + 10);
        ev_q.push_back(w + 15);
        wait_cyc(w + 5);
        wr(2, R_STAT, 1);
        wait_cyc(w + 10);
        wr(2, R_STAT, 1);
        wait_cyc(w + 14);
        wr(2, R_STAT, 1);               // W1C lands on the same edge as the set
        rd(2, R_STAT, 1, "set_beats_w1c");
        wr(2, R_CTRL, 0);
        wr(2, R_STAT, 1);
        rd(2, R_STAT, 0, "reload_clear");
        check("reload_irq_low", IRQ, 0);

        // Channel 1: stop at COUNT=4, then re-enable and reload
        wr(1, R_PRE, 10);
        wr(1, R_CTRL, 32'h1);
        w = cyc;
        wait_cyc(w + 8);
        wr(1, R_CTRL, 0);
        rd(1, R_CNT, 4, "stop_count");
        ticks(3);
        rd(1, R_CNT, 4, "stop_count_hold");
        rd(1, R_CTRL, 0, "stop_ctrl");
        wr(1, R_CTRL, 32'h9);
        w = cyc;
        ev_q.push_back(w + 12);
        wait_cyc(w + 2);
        rd(1, R_CNT, 10, "reload_count");
        wait_ev(50);
        ticks(2);
        rd(1, R_CNT, 0, "ch1_done_count");
        wr(1, R_STAT, 1);

        // Channels 0 and 3 both run; only channel 3 has IM set
        wr(0, R_PRE, 4);
        wr(0, R_CTRL, 32'h1);
        wr(3, R_PRE, 6);
        wr(3, R_CTRL, 32'h9);
        ev_q.push_back(cyc + 8);
        wait_ev(50);
        ticks(1);
        check("irq_vec_ch3", irq_vec, 4'b1000);
        rd(0, R_STAT, 1, "ch0_pend_masked");
        rd(3, R_PRE, 6, "a_ch3_preset");
        rdb(3, R_PRE, 0, "b_ch3_absent");
        rdb(2, R_PRE, 0, "b_ch2_absent");
        rdb(0, R_PRE, 4, "b_ch0_preset");
        wr(0, R_STAT, 1);
        wr(3, R_STAT, 1);
        check("irq_cleared", IRQ, 0);
        wr(0, R_PRE, 32'h1234);
        rd(0, R_PRE, 32'h1234, "a_preset_wide");
        rdb(0, R_PRE, 32'h34, "b_preset_narrow");

        // PRESET=0 behaves like 1. COUNT is read-only.
        wr(1, R_PRE, 0);
        wr(1, R_CTRL, 32'h9);
        ev_q.push_back(cyc + 3);
        wait_ev(50);
        ticks(2);
        wr(1, R_CNT, 32'h55);
        rd(1, R_CNT, 0, "count_ro");
        wr(1, R_STAT, 1);

`ifdef MULTI_TIMER_PRESCALE_EN
        wr(0, R_PRE, 4);
        wr(0, R_CTRL, 32'h29);
        ev_q.push_back(cyc + 14);
        rd(0, R_CTRL, 32'h29, "psc_readback");
        wait_ev(60);
        ticks(2);
        rd(0, R_CTRL, 32'h28, "psc_done_ctrl");
        wr(0, R_STAT, 1);
`else
        wr(0, R_PRE, 4);
        wr(0, R_CTRL, 32'hF1);
        rd(0, R_CTRL, 32'h01, "psc_absent");
        ticks(10);
        rd(0, R_STAT, 1, "nopsc_pend");
        wr(0, R_STAT, 1);
        rd(0, R_CTRL, 0, "nopsc_done_ctrl");
`endif

        // Asynchronous reset in the middle of a count
        wr(3, R_PRE, 2);
        wr(3, R_CTRL, 32'h9);
        ev_q.push_back(cyc + 4);
        wait_ev(50);
        ticks(1);
        check("pre_rst_irq", IRQ, 1);
        wr(0, R_PRE, 20);
        wr(0, R_CTRL, 32'h9);
        ticks(5);
        reset = 1'b0;
        #1;
        check("midrst_irq", IRQ, 0);
        check("midrst_irq_vec", irq_vec, 0);
        rd(0, R_CTRL, 0, "midrst_ctrl");
        rd(0, R_PRE, 0, "midrst_preset");
        rd(0, R_CNT, 0, "midrst_count");
        rd(3, R_STAT, 0, "midrst_pend");
        reset = 1'b1;
        ticks(1);
        check("postrst_irq", IRQ, 0);
        ticks(40);
        rd(0, R_CNT, 0, "postrst_count");
        rd(0, R_CTRL, 0, "postrst_ctrl");

        check("ev_q_empty", ev_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
